fetch_unit: RTL and testbench

//  Front end of the tag/jump protocol whose far end is the retire stage. Fetches 32-bit words

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetches words over req/ack, stamps PC and tag, queues them for decode.
// Latency: a word acked on cycle N is visible at the head on cycle N+1; head fields have zero added latency.
// Backpressure: stall holds the head; fetching pauses once queued plus outstanding would exceed DEPTH. Optional: FLUSH_ON_REDIRECT_EN.
module fetch_unit #(
    parameter logic [31:0] START_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [3:0]  instruction_tag
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  tag;
    } entry_t;

    state_t         state;
    logic [31:0]    pc;
    logic [3:0]     tag;
    logic [3:0]     req_tag;
    logic           stale;
    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    logic           ack_vld;
    logic           push;
    logic           pop;
    logic           flush;
    logic [AW:0]    count_nxt;
    logic [31:0]    pc_nxt;
    logic [3:0]     tag_nxt;

    always_comb begin
        ack_vld = (state == WAIT) && imem_ack;
        pop     = instr_valid && !stall;
`ifdef FLUSH_ON_REDIRECT_EN
        // Responses belonging to a pre-redirect request never reach decode.
        flush   = redirect;
        push    = ack_vld && !redirect && !stale;
`else
        flush   = 1'b0;
        push    = ack_vld;
`endif
        count_nxt = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        tag_nxt   = redirect ? tag + 4'd1 : tag;
        // A stale ack must not step pc: pc already holds the redirect target.
        if (redirect)
            pc_nxt = new_pc & ~32'h3;
        else if (ack_vld && !stale)
            pc_nxt = pc + 32'd4;
        else
            pc_nxt = pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= START_PC;
            pc        <= START_PC;
            tag       <= 4'd0;
            req_tag   <= 4'd0;
            stale     <= 1'b0;
        end else begin
            pc  <= pc_nxt;
            tag <= tag_nxt;
            if (ack_vld)
                stale <= 1'b0;
            else if (state == WAIT && redirect)
                stale <= 1'b1;
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_nxt;
                        req_tag   <= tag_nxt;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (count_nxt < FULL) begin
                            imem_addr <= pc_nxt;
                            req_tag   <= tag_nxt;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{instr: imem_rdata, pc: imem_addr, tag: req_tag};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

    assign instr_valid     = (count != '0);
    assign instruction     = mem[rd_ptr].instr;
    assign pc_out          = mem[rd_ptr].pc;
    assign instruction_tag = mem[rd_ptr].tag;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] START_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] new_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [3:0]  instruction_tag;

    fetch_unit #(.START_PC(START_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .new_pc(new_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .stall(stall), .instr_valid(instr_valid),
        .instruction(instruction), .pc_out(pc_out), .instruction_tag(instruction_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef FLUSH_ON_REDIRECT_EN
    bit flush_mode = 1'b1;
`else
    bit flush_mode = 1'b0;
`endif

    // Reference model: program counter, current tag and the single outstanding fetch.
    logic [31:0] m_pc;
    logic [3:0]  m_tag;
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [3:0]  m_rtag;
    bit          ack_d, redir_d;
    logic [31:0] npc_d;
    bit          model_on = 1'b0;

    int ack_pct = 100, redir_pct = 0, stall_pct = 0;
    bit stall_force = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every mid-cycle, the head must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("instr_valid", 32'(instr_valid), 32'(sb_q.size() != 0));
                if (instr_valid && !stall && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("instruction", instruction, e.instr);
                    check("pc_out", pc_out, e.pc);
                    check("instruction_tag", 32'(instruction_tag), 32'(e.tag));
                end
            end
        end
    end

    task automatic model_reset();
        sb_q.delete();
        m_pc = START_PC; m_tag = 4'd0; m_out = 1'b0; m_stale = 1'b0;
        m_addr = '0; m_rtag = '0; ack_d = 1'b0; redir_d = 1'b0; npc_d = '0;
    endtask

    // Apply the effects of the clock edge that just passed, using the inputs driven before it.
    task automatic model_edge();
        bit acked;
        acked = ack_d && m_out;
        if (acked) begin
            if (!(flush_mode && (m_stale || redir_d)))
                sb_q.push_back('{mem_word(m_addr), m_addr, m_rtag});
            m_out = 1'b0;
        end
        if (redir_d) begin
            if (flush_mode) sb_q.delete();
            if (m_out) m_stale = 1'b1;
            m_pc  = npc_d & ~32'h3;
            m_tag = m_tag + 4'd1;
        end else if (acked && !m_stale) begin
            m_pc = m_pc + 32'd4;
        end
        if (acked) m_stale = 1'b0;
        check("occupancy_le_depth", 32'(sb_q.size() <= DEPTH), 32'd1);
        if (m_out) begin
            check("imem_req_held", 32'(imem_req), 32'd1);
        end else if (imem_req) begin
            m_out = 1'b1; m_addr = m_pc; m_rtag = m_tag; m_stale = 1'b0;
        end
        if (m_out) check("imem_addr", imem_addr, m_addr);
    endtask

    task automatic drive();
        bit a, r;
        a = imem_req && ($urandom_range(99) < ack_pct);
        r = ($urandom_range(99) < redir_pct);
        imem_ack   = a;
        imem_rdata = a ? mem_word(m_addr) : $urandom;
        redirect   = r;
        new_pc     = r ? ($urandom & 32'h0000_0FFF) : $urandom;
        stall      = stall_force || ($urandom_range(99) < stall_pct);
        ack_d = a; redir_d = r; npc_d = new_pc;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            model_edge();
            drive();
        end
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_imem_addr", imem_addr, START_PC);
        check("rst_instruction", instruction, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_tag", 32'(instruction_tag), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        model_on = 1'b1;

        // Always-ack, no stall: sequential addresses, tag 0, first word two cycles after release.
        ack_pct = 100; redir_pct = 0; stall_pct = 0;
        run(1);
        check("first_valid_c1", 32'(instr_valid), 32'd0);
        run(1);
        check("first_valid_c2", 32'(instr_valid), 32'd1);
        run(18);

        // Decode stalled: queue fills to DEPTH and requests stop.
        stall_force = 1'b1;
        run(20);
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_full", 32'(sb_q.size()), 32'(DEPTH));
        stall_force = 1'b0;
        run(20);

        // Seventeen back-to-back redirects with the request held outstanding.
        ack_pct = 0; redir_pct = 100;
        run(17);
        ack_pct = 100; redir_pct = 0;
        run(15);

        // Random mixes of acks, redirects and stalls.
        ack_pct = 50; redir_pct = 15; stall_pct = 30;
        run(800);
        ack_pct = 90; redir_pct = 40; stall_pct = 10;
        run(800);
        ack_pct = 30; redir_pct = 5; stall_pct = 70;
        run(800);

        // Reset while a request is outstanding behind three queued words.
        ack_pct = 100; redir_pct = 0; stall_pct = 0; stall_force = 1'b1;
        guard = 0;
        while (!(sb_q.size() == 3 && m_out) && guard < 50) begin
            if (sb_q.size() >= 2) ack_pct = 0;
            if (sb_q.size() < 3) ack_pct = 100;
            run(1);
            guard++;
        end
        check("t6_setup_reached", 32'(guard < 50), 32'd1);
        ack_pct = 0;
        run(2);
        @(posedge clk); #1;
        model_edge();
        imem_ack = 1'b0; redirect = 1'b0;
        reset = 1'b0;
        model_on = 1'b0;
        #1;
        check("t6_req_cleared", 32'(imem_req), 32'd0);
        check("t6_valid_cleared", 32'(instr_valid), 32'd0);
        check("t6_addr_reset", imem_addr, START_PC);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        ack_d = 1'b1;
        model_on = 1'b1;
        stall_force = 1'b0;
        ack_pct = 100;
        run(1);
        check("t6_first_addr", imem_addr, START_PC);
        run(10);
        ack_pct = 60; redir_pct = 10; stall_pct = 25;
        run(400);

        // Let the queue drain so every expected entry gets compared.
        redir_pct = 0; ack_pct = 0; stall_pct = 0;
        run(DEPTH + 4);
        check("drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
